xorshift_prng_stream: RTL and testbench

- Multi-channel xorshift PRNG with a valid/ready output stream, run-time reseed and a warm-up discard phase.
- Each of NUM_CH independent generators produces one WIDTH-bit word per accepted transfer; the words are concatenated on one bus.
- Sits between the random-source slot and the DNA coding datapath and supersedes the fixed-rate free-running generator.

---
 rtl/xorshift_prng_stream.sv | 78 +++++++
 tb/tb_xorshift_prng_stream.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/xorshift_prng_stream.sv
// xorshift_prng_stream: NUM_CH lockstep xorshift generators behind a valid/ready stream with reseed and warm-up; defining PRNG_WORD_CNT_EN adds the word_cnt transfer counter
module xorshift_prng_stream #(
  parameter int          WIDTH     = 32,
  parameter int          NUM_CH    = 4,
  parameter logic [63:0] SEED      = 64'd1,
  parameter int          SEED_STEP = 7,
  parameter int          WARMUP    = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    seed_load,
  input  logic [WIDTH-1:0]        seed_in,
  input  logic                    rand_ready,
  output logic                    rand_valid,
  output logic [NUM_CH*WIDTH-1:0] rand_out
`ifdef PRNG_WORD_CNT_EN
  ,
  output logic [31:0]             word_cnt
`endif
);
  typedef enum logic {S_WARM, S_RUN} state_t;
  localparam state_t INIT = (WARMUP == 0) ? S_RUN : S_WARM;
  function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> ((WIDTH == 64) ? 7 : 17));
    y = y ^ (y << ((WIDTH == 64) ? 17 : 5));
    return y;
  endfunction
  // an all-zero state would lock the generator at zero forever
  function automatic logic [WIDTH-1:0] ch_seed(input logic [WIDTH-1:0] base, input int i);
    logic [WIDTH-1:0] s;
    s = base + WIDTH'(i * SEED_STEP);
    return (s == '0) ? WIDTH'(32'h9E37_79B9) : s;
  endfunction
  state_t     st_q, st_d;
  logic [7:0] warm_q, warm_d;
  logic       fire, adv;
  assign rand_valid = (st_q == S_RUN);
  assign fire       = rand_valid & rand_ready;
  always_comb begin
    st_d   = st_q;
    warm_d = warm_q;
    adv    = 1'b0;
    if (seed_load) begin
      st_d   = INIT;
      warm_d = '0;
    end else if (st_q == S_WARM) begin
      adv    = 1'b1;
      warm_d = warm_q + 8'd1;
      st_d   = (warm_q == 8'(WARMUP - 1)) ? S_RUN : S_WARM;
    end else begin
      adv = fire;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st_q   <= INIT;
      warm_q <= '0;
    end else begin
      st_q   <= st_d;
      warm_q <= warm_d;
    end
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [WIDTH-1:0] x_q;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) x_q <= ch_seed(WIDTH'(SEED), i);
      else x_q <= seed_load ? ch_seed(seed_in, i) : adv ? step(x_q) : x_q;
    assign rand_out[i*WIDTH +: WIDTH] = x_q;
  end
`ifdef PRNG_WORD_CNT_EN
  logic [31:0] cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else if (fire) cnt_q <= cnt_q + 32'd1;
  assign word_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_xorshift_prng_stream.sv
// tb_xorshift_prng_stream: three configurations (32b/warm-up 1, 32b/no warm-up, 64b/step 0/warm-up 3) against a sequence-level golden model
module tb_xorshift_prng_stream;
  logic         clk = 0, rst_n = 1, seed_load = 0;
  logic [63:0]  seed_in = '0;
  logic [2:0]   rdy = '0, vld;
  logic [127:0] o0, o1, o2;
`ifdef PRNG_WORD_CNT_EN
  logic [31:0]  wc [3];
`endif
  always #5 clk = ~clk;

  xorshift_prng_stream #(.WIDTH(32), .NUM_CH(4), .SEED(1), .SEED_STEP(7), .WARMUP(1)) u0 (
    .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed_in(seed_in[31:0]),
    .rand_ready(rdy[0]), .rand_valid(vld[0]), .rand_out(o0)
`ifdef PRNG_WORD_CNT_EN
    , .word_cnt(wc[0])
`endif
  );
  xorshift_prng_stream #(.WIDTH(32), .NUM_CH(4), .SEED(1), .SEED_STEP(7), .WARMUP(0)) u1 (
    .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed_in(seed_in[31:0]),
    .rand_ready(rdy[1]), .rand_valid(vld[1]), .rand_out(o1)
`ifdef PRNG_WORD_CNT_EN
    , .word_cnt(wc[1])
`endif
  );
  xorshift_prng_stream #(.WIDTH(64), .NUM_CH(2), .SEED(1), .SEED_STEP(0), .WARMUP(3)) u2 (
    .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed_in(seed_in),
    .rand_ready(rdy[2]), .rand_valid(vld[2]), .rand_out(o2)
`ifdef PRNG_WORD_CNT_EN
    , .word_cnt(wc[2])
`endif
  );

  localparam int MW [3] = '{32, 32, 64};
  localparam int MN [3] = '{4, 4, 2};
  localparam int MS [3] = '{7, 7, 0};
  localparam int MU [3] = '{1, 0, 3};

  // model: accepted word k after a (re)seed is step^(WARMUP+k) of the channel seed
  logic [63:0] m_base [3];
  int          m_since [3], m_k [3];
  logic [31:0] m_cnt [3];
  int          tests = 0, fails = 0;

  function automatic logic [63:0] stepf(input int w, input logic [63:0] x);
    logic [31:0] y;
    if (w == 32) begin
      y = x[31:0];
      y ^= y << 13; y ^= y >> 17; y ^= y << 5;
      return {32'd0, y};
    end
    x ^= x << 13; x ^= x >> 7; x ^= x << 17;
    return x;
  endfunction

  function automatic logic [63:0] expw(input int d, input int i);
    logic [63:0] x;
    x = m_base[d] + 64'(i * MS[d]);
    if (MW[d] == 32) x &= 64'hFFFF_FFFF;
    if (x == 0) x = 64'h9E37_79B9;
    for (int n = 0; n < MU[d] + m_k[d]; n++) x = stepf(MW[d], x);
    return x;
  endfunction

  function automatic logic [63:0] dword(input int d, input int i);
    case (d)
      0:       return {32'd0, o0[i*32 +: 32]};
      1:       return {32'd0, o1[i*32 +: 32]};
      default: return o2[i*64 +: 64];
    endcase
  endfunction

  always @(posedge clk)
    for (int d = 0; d < 3; d++) begin
      bit v;
      v = m_since[d] >= MU[d];
      if (!rst_n) begin
        m_base[d] = 64'd1; m_since[d] = 0; m_k[d] = 0; m_cnt[d] = 0;
      end else begin
        if (v && rdy[d]) m_cnt[d]++;
        if (seed_load) begin
          m_base[d]  = (MW[d] == 32) ? {32'd0, seed_in[31:0]} : seed_in;
          m_since[d] = 0;
          m_k[d]     = 0;
        end else begin
          if (v && rdy[d]) m_k[d]++;
          if (!v) m_since[d]++;
        end
      end
    end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 3; d++) begin
      bit v;
      v = m_since[d] >= MU[d];
      chk($sformatf("valid[%0d]", d), 128'(vld[d]), 128'(v));
      if (v)
        for (int i = 0; i < MN[d]; i++)
          chk($sformatf("word[%0d][%0d]", d, i), 128'(dword(d, i)), 128'(expw(d, i)));
`ifdef PRNG_WORD_CNT_EN
      chk($sformatf("word_cnt[%0d]", d), 128'(wc[d]), 128'(m_cnt[d]));
`endif
    end
  endtask

  typedef struct {
    logic [63:0]  seed;
    logic [2:0]   v;
    logic [127:0] e1;
    logic [127:0] e2;
  } vec_t;
  vec_t tbl [5];

  initial begin
    tbl[0] = '{64'h1_0000_0005, 3'b010, {32'd26, 32'd19, 32'd12, 32'd5}, {2{64'h1_0000_0005}}};
    tbl[1] = '{64'd0, 3'b010, {32'd21, 32'd14, 32'd7, 32'h9E37_79B9}, {2{64'h9E37_79B9}}};
    tbl[2] = '{64'hFFFF_FFF9, 3'b010, {32'd14, 32'd7, 32'h9E37_79B9, 32'hFFFF_FFF9}, {2{64'hFFFF_FFF9}}};
    tbl[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 3'b010, {32'd20, 32'd13, 32'd6, 32'hFFFF_FFFF}, {2{64'hFFFF_FFFF_FFFF_FFFF}}};
    tbl[4] = '{64'd1, 3'b010, {32'd22, 32'd15, 32'd8, 32'd1}, {2{64'd1}}};
    #2 rst_n = 0;
    @(negedge clk);
    check_all();
    chk("rst_valid", 128'(vld), 128'(3'b010));
    rst_n = 1;
    rdy = 3'b111;
    #1 chk("rst_out_u1", o1, {32'd22, 32'd15, 32'd8, 32'd1});
    @(negedge clk);
    chk("first_word_u0", 128'(o0[31:0]), 128'h0004_2021);
    chk("first_valid", 128'(vld), 128'(3'b011));
    check_all();
    rdy = '0;
    foreach (tbl[n]) begin
      seed_load = 1;
      seed_in = tbl[n].seed;
      @(negedge clk);
      seed_load = 0;
      chk($sformatf("tbl%0d_valid", n), 128'(vld), 128'(tbl[n].v));
      chk($sformatf("tbl%0d_u1", n), o1, tbl[n].e1);
      chk($sformatf("tbl%0d_u2", n), o2, tbl[n].e2);
      check_all();
    end
    repeat (4) begin
      @(negedge clk);
      check_all();
    end
    chk("coll_pre_valid", 128'(vld[2]), 128'd1);
    rdy = 3'b111;
    seed_load = 1;
    seed_in = 64'd5;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      seed_load = 0;
      chk($sformatf("coll_valid%0d", j), 128'(vld[2]), 128'(j == 3));
      check_all();
    end
    chk("coll_word", 128'(o2[63:0]), 128'(stepf(64, stepf(64, stepf(64, 64'd5)))));
    for (int c = 0; c < 1500; c++) begin
      rst_n = 1;
      rdy = 3'($urandom_range(0, 7)) | 3'($urandom_range(0, 7));
      seed_load = ($urandom_range(0, 149) == 0);
      seed_in = {$urandom, $urandom};
      if (c == 750) begin
        seed_load = 0;
        rst_n = 0;
        #1;
        chk("midrst_valid", 128'(vld), 128'(3'b010));
        chk("midrst_u0", o0, {32'd22, 32'd15, 32'd8, 32'd1});
        chk("midrst_u2", o2, {2{64'd1}});
      end
      @(negedge clk);
      check_all();
    end
    rst_n = 0;
    seed_load = 0;
    @(negedge clk);
    rst_n = 1;
    rdy = 3'b100;
    repeat (13) begin
      @(negedge clk);
      check_all();
    end
`ifdef PRNG_WORD_CNT_EN
    chk("w64_cnt10", 128'(wc[2]), 128'd10);
    rdy = '0;
    force u1.cnt_q = 32'hFFFF_FFFF;
    m_cnt[1] = 32'hFFFF_FFFF;
    #1 release u1.cnt_q;
    rdy = 3'b010;
    @(negedge clk);
    chk("cnt_wrap", 128'(wc[1]), 128'd0);
    check_all();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
